// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the LSU SRAM responder: FSM states, counter sizing
// and the random-delay LFSR constants.
package sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_LATENCY = 15;
    // Wide enough for MAX_LATENCY plus the 0..3 cycles the random delay may add.
    localparam int CNT_W = $clog2(MAX_LATENCY + 4);

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// DEPTH_WORDS x 32 data array with a synchronous byte-masked write and an
// asynchronous read on the same index; contents are never cleared.
module sram_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       wmask,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/lsu_sram_responder.sv
// Handshaked, latency-bearing data-memory responder for the LSU.
// Define SRAM_RAND_DELAY_EN to add a pseudo-random 0..3 cycles to every access.
module lsu_sram_responder
    import sram_resp_pkg::*;
#(
    parameter int               ADDR_W      = 32,
    parameter int               DATA_W      = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int               LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, total_delay, load_cnt;
    logic               accept, wait_done, do_access;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [3:0]         lat_wmask;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [3:0]         acc_wmask;
    logic               in_range;
    logic [ADDR_W:0]    addr_limit;
    logic [IDX_W-1:0]   index;
    logic [DATA_W-1:0]  bank_rdata;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_feedback(lfsr)};
        end
    end

    assign total_delay = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
    assign total_delay = CNT_W'(LATENCY);
`endif

    assign load_cnt  = total_delay - CNT_W'(1);
    assign accept    = (state == IDLE) && req_valid;
    assign wait_done = (state == WAIT) && (cnt == CNT_W'(1));
    // The memory is touched exactly on the edge that enters RESP.
    assign do_access = (accept && (load_cnt == '0)) || wait_done;

    // On the IDLE->RESP edge the request is still on the inputs, not yet latched.
    assign acc_we    = (state == IDLE) ? req_we    : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_wmask = (state == IDLE) ? req_wmask : lat_wmask;

    assign addr_limit = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);
    assign in_range   = (acc_addr >= BASE_ADDR) && ({1'b0, acc_addr} < addr_limit);
    assign index      = IDX_W'((acc_addr - BASE_ADDR) >> 2);

    sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (do_access && acc_we && in_range),
        .wmask (acc_wmask),
        .idx   (index),
        .wdata (acc_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (load_cnt == '0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask;
                cnt       <= load_cnt;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_access) begin
                resp_err   <= !in_range;
                resp_rdata <= (acc_we || !in_range) ? '0 : bank_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram_responder.sv
// Self-checking bench for lsu_sram_responder: two instances (LATENCY 1 and 4) driven
// from a directed vector table plus hand-written reset, throughput and random sequences.
module tb_lsu_sram_responder;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wmask  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t        vecs[$];
    logic [31:0] model [2][8];

    always #5 clk = ~clk;

    lsu_sram_responder #(.LATENCY(LAT0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_wmask  (req_wmask[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    lsu_sram_responder #(.LATENCY(LAT1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_wmask  (req_wmask[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic vec_t mkv(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] mask,
                                 input int hold, input logic [31:0] exp_rdata,
                                 input logic exp_err);
        vec_t v;
        v.d = d; v.we = we; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Random-delay builds may stretch any delay by 0..3 cycles.
    task automatic check_delay(input string name, input int act, input int nominal);
        logic ok;
`ifdef SRAM_RAND_DELAY_EN
        ok = (act >= nominal) && (act <= nominal + 3);
`else
        ok = (act == nominal);
`endif
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d cycles, want %0d", name, act, nominal);
        end
    endtask

    // One full transaction: accept, count latency, hold resp_ready low for 'hold' cycles.
    task automatic apply_stimulus(input int d, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] mask,
                                  input int hold, input string tag,
                                  output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        check_bit({tag, " req_ready idle"}, req_ready[d], 1'b1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wmask[d] = mask;
        resp_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_wdata[d] = ~wdata;
        req_addr[d]  = addr ^ 32'h0000_0040;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!resp_valid[d]) check_bit({tag, " req_ready busy"}, req_ready[d], 1'b0);
        end while (!resp_valid[d] && lat < 40);
        if (!resp_valid[d]) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL %s timeout: resp_valid still 0 after %0d cycles", tag, lat);
            resp_ready[d] = 1'b0;
            rdata = 'x; err = 1'bx;
            return;
        end
        check_delay({tag, " latency"}, lat, lat_of(d));
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_bit({tag, " hold valid"}, resp_valid[d], 1'b1);
            check_output({tag, " hold rdata"}, resp_rdata[d], rdata);
            check_bit({tag, " hold err"}, resp_err[d], err);
            check_bit({tag, " hold req_ready"}, req_ready[d], 1'b0);
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        check_bit({tag, " valid drop"}, resp_valid[d], 1'b0);
        check_bit({tag, " req_ready back"}, req_ready[d], 1'b1);
        resp_ready[d] = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc, first, second;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wmask[d] = '0; resp_ready[d] = 1'b0;
        end

        // Directed table: {dut, we, addr, wdata, mask, hold, exp_rdata, exp_err}
        vecs.push_back(mkv(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         0));
        vecs.push_back(mkv(0, 0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mkv(0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 32'h0,         0));
        vecs.push_back(mkv(0, 1, 32'h8000_0020, 32'h0000_AA00, 4'h2, 0, 32'h0,         0));
        vecs.push_back(mkv(0, 0, 32'h8000_0020, 32'h0,         4'h0, 0, 32'h1122_AA44, 0));
        vecs.push_back(mkv(0, 1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         0));
        vecs.push_back(mkv(0, 1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 1, 32'h0,         0));
        vecs.push_back(mkv(0, 0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 32'h0,         1));
        vecs.push_back(mkv(0, 1, 32'h8000_1000, 32'h1234_5678, 4'hF, 0, 32'h0,         1));
        vecs.push_back(mkv(0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 0, 32'h0,         1));
        vecs.push_back(mkv(0, 0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0BAD_F00D, 0));
        vecs.push_back(mkv(0, 0, 32'h8000_0FFC, 32'h0,         4'h0, 2, 32'hCAFE_F00D, 0));
        vecs.push_back(mkv(0, 1, 32'h8000_0010, 32'h0000_0000, 4'h0, 0, 32'h0,         0));
        vecs.push_back(mkv(0, 0, 32'h8000_0012, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mkv(0, 0, 32'h8000_1000, 32'h0,         4'h0, 1, 32'h0,         1));
        vecs.push_back(mkv(1, 1, 32'h8000_0040, 32'h5555_5555, 4'hF, 0, 32'h0,         0));
        vecs.push_back(mkv(1, 0, 32'h8000_0040, 32'h0,         4'h0, 3, 32'h5555_5555, 0));
        vecs.push_back(mkv(1, 1, 32'h8000_0044, 32'h0000_0000, 4'hF, 0, 32'h0,         0));
        vecs.push_back(mkv(1, 1, 32'h8000_0044, 32'hA5A5_A5A5, 4'h9, 1, 32'h0,         0));
        vecs.push_back(mkv(1, 0, 32'h8000_0044, 32'h0,         4'h0, 3, 32'hA500_00A5, 0));
        vecs.push_back(mkv(1, 0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2, 32'h0,         1));

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("reset%0d req_ready", d), req_ready[d], 1'b0);
            check_bit($sformatf("reset%0d resp_valid", d), resp_valid[d], 1'b0);
            check_output($sformatf("reset%0d rdata", d), resp_rdata[d], 32'h0);
            check_bit($sformatf("reset%0d err", d), resp_err[d], 1'b0);
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                           vecs[i].hold, $sformatf("vec%0d", i), rd, er);
            check_output($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check_bit($sformatf("vec%0d err", i), er, vecs[i].exp_err);
        end

        // Reset while a store waits: it must never reach memory.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8000_0040;
        req_wdata[1] = 32'hAAAA_AAAA; req_wmask[1] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_wait resp_valid", resp_valid[1], 1'b0);
        check_bit("rst_wait req_ready in rst", req_ready[1], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("rst_wait req_ready after", req_ready[1], 1'b1);
        repeat (6) @(negedge clk);
        check_bit("rst_wait no late resp", resp_valid[1], 1'b0);
        apply_stimulus(1, 0, 32'h8000_0040, 32'h0, 4'h0, 0, "rst_wait load", rd, er);
        check_output("rst_wait load rdata", rd, 32'h5555_5555);

        // Reset while the response is pending: the store is already committed.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8000_0048;
        req_wdata[1] = 32'h1357_9BDF; req_wmask[1] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!resp_valid[1] && cyc < 40);
        check_bit("rst_resp reached RESP", resp_valid[1], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_resp resp_valid", resp_valid[1], 1'b0);
        rst = 1'b0;
        apply_stimulus(1, 0, 32'h8000_0048, 32'h0, 4'h0, 0, "rst_resp load", rd, er);
        check_output("rst_resp load rdata", rd, 32'h1357_9BDF);

        // Back-to-back requests with resp_ready held high: accepts are total_delay+1 apart.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h8000_0010;
        resp_ready[0] = 1'b1;
        cyc = 0; first = -1; second = -1;
        while (second < 0 && cyc < 30) begin
            if (req_ready[0]) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (second < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        if (second < 0) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL b2b timeout: second accept not seen in %0d cycles", cyc);
        end else begin
            check_delay("b2b accept spacing", second - first, LAT0 + 1);
        end
        repeat (8) @(negedge clk);
        check_bit("b2b drained", resp_valid[0], 1'b0);
        resp_ready[0] = 1'b0;

        // Random traffic against a byte-accurate scoreboard on a small window.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                model[d][w] = $urandom;
                apply_stimulus(d, 1, 32'h8000_0100 + 32'(w * 4), model[d][w], 4'hF, 0,
                               $sformatf("init%0d_%0d", d, w), rd, er);
                check_output($sformatf("init%0d_%0d rdata", d, w), rd, 32'h0);
            end
        end
        for (int i = 0; i < 40; i++) begin
            int          d, w, hold;
            logic        we;
            logic [31:0] data;
            logic [3:0]  mask;
            d    = i % 2;
            w    = $urandom_range(0, 7);
            we   = 1'($urandom_range(0, 1));
            data = $urandom;
            mask = 4'($urandom);
            hold = $urandom_range(0, 2);
            apply_stimulus(d, we, 32'h8000_0100 + 32'(w * 4), data, mask, hold,
                           $sformatf("rnd%0d", i), rd, er);
            if (we) begin
                check_output($sformatf("rnd%0d store rdata", i), rd, 32'h0);
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) model[d][w][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                check_output($sformatf("rnd%0d load rdata", i), rd, model[d][w]);
            end
            check_bit($sformatf("rnd%0d err", i), er, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
